skid_fifo: RTL and testbench
============================

Name: skid_fifo

Overview:
- Parametrised elastic buffer for valid/ready streams: a DEPTH-entry circular buffer with selectable fall-through or registered output.
- ready_o is derived only from internal occupancy, never combinationally from ready_i, so it breaks the backpressure timing path between pipeline stages.
- Adds a synchronous flush and an occupancy output for the pipeline control logic that drains stages on redirect.

Parameters:
- T, logic, payload type carried on data_i/data_o.
- DEPTH, 2, number of storage entries; must be a power of two and >= 2, otherwise elaboration error.
- FALL_THROUGH, 1, 1 = empty buffer forwards data_i to data_o in the same cycle; 0 = output always comes from storage (minimum 1-cycle latency).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush_i  input  1  synchronous discard of all stored entries.
- valid_i  input  1  upstream beat valid.
- data_i  input  $bits(T)  upstream payload.
- ready_o  output  1  buffer can accept a beat this cycle.
- valid_o  output  1  downstream beat valid.
- data_o  output  $bits(T)  downstream payload.
- ready_i  input  1  downstream accepts the beat.
- count_o  output  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Transfers: input beat accepted iff valid_i && ready_o; output beat consumed iff valid_o && ready_i.
- State: wr_ptr, rd_ptr (each $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally), count register (0..DEPTH). Entries are written at wr_ptr and read at rd_ptr. Strict FIFO order.
- ready_o = !rst && !flush_i && (count < DEPTH).
  - No dependence on ready_i.
  - At full, a simultaneous pop does not enable a push in the same cycle.
- FALL_THROUGH=1:
  - count==0: valid_o = valid_i, data_o = data_i.
    - Beat consumed same cycle: bypass, storage and count unchanged.
    - Not consumed: beat is written, count becomes 1.
  - count>0: valid_o=1, data_o = mem[rd_ptr]. An incoming beat is enqueued behind the stored ones.
- FALL_THROUGH=0:
  - valid_o = (count != 0); data_o = mem[rd_ptr].
  - Every accepted beat is written; earliest appearance at data_o is the cycle after acceptance.
- Count update when not in rst/flush:
  - +1 on a stored push without pop.
  - -1 on a pop from storage without push.
  - Unchanged on push+pop or on a bypass.
- Stability: once valid_o=1 with ready_i=0, valid_o stays 1 and data_o stays unchanged until consumed (except rst/flush).
- Throughput: sustained 1 beat/cycle with continuous valid_i and ready_i in both modes, from any occupancy below DEPTH.
- flush_i:
  - In the flush cycle, valid_o=0 and ready_o=0, so no transfers occur.
  - Next cycle: count=0 and both pointers are 0.
  - Memory contents are not cleared.
- rst:
  - Priority rst > flush.
  - While rst=1: valid_o=0 and ready_o=0 (combinationally gated).
  - Next cycle: count=0, pointers 0, all memory entries '0. After release: data_o='0 (FALL_THROUGH=0) or data_i (FALL_THROUGH=1), count_o=0, ready_o=1.
  - Reset mid-stream drops all stored and in-flight beats.
- data_o is don't-care whenever valid_o=0; benches must not check it then.

Test Plan:
- Bypass (DEPTH=2, FALL_THROUGH=1): data_i=0xA1 with valid_i=1, ready_i=1 -> data_o=0xA1 same cycle, count_o stays 0, ready_o=1 throughout.
- Fill and backpressure (DEPTH=4, FALL_THROUGH=0): push 0x10..0x13 with ready_i=0 -> count_o 1,2,3,4 and ready_o=0 after the 4th. Hold valid_i=1, data_i=0x14 -> not accepted. Raise ready_i=1 -> output 0x10,0x11,0x12,0x13 on consecutive cycles, then 0x14.
- Full with simultaneous pop (DEPTH=2): count=2, valid_i=1, ready_i=1 -> one pop, no push, count_o=1 next cycle; push accepted the following cycle.
- Wrap-around (DEPTH=4, FALL_THROUGH=1): stream 0..19 with ready_i toggled pseudo-randomly 50% -> output sequence 0..19 in order, no loss or duplication, count_o never exceeds 4.
- Flush mid-stream (DEPTH=4): three entries 0x21..0x23 stored, flush_i=1 for one cycle -> valid_o=0, ready_o=0 that cycle; count_o=0 next cycle; next pushed 0x30 is the first beat out.
- Reset mid-operation (DEPTH=4): rst=1 for one cycle with count=3 -> valid_o=0, ready_o=0 while asserted; count_o=0 after; no stale beat ever appears at the output.

Source files
------------

// File: rtl/skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : skid_fifo
// Purpose  : Elastic valid/ready buffer built on a DEPTH-entry circular
//            buffer. The output is either fall-through (an empty buffer
//            forwards the input in the same cycle) or registered (the output
//            always comes from storage). ready_o depends only on internal
//            occupancy, so the backpressure path between stages is cut.
//            A synchronous flush and an occupancy count support drain logic.
// Ports    : clk, rst        - rising-edge clock, synchronous active-high reset
//            flush_i         - discard all stored entries (synchronous)
//            valid_i, data_i - upstream beat, ready_o - buffer can accept
//            valid_o, data_o - downstream beat, ready_i - downstream accepts
//            count_o         - number of stored entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module skid_fifo #(
    parameter type T            = logic,
    parameter int  DEPTH        = 2,
    parameter bit  FALL_THROUGH = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  T                           data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output T                           data_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    // Pointers wrap naturally only when DEPTH is a power of two.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("skid_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    T                  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_gate;     // reset or flush: block every transfer this cycle
    logic w_empty;
    logic w_push;     // upstream beat accepted
    logic w_pop;      // downstream beat consumed
    logic w_bypass;   // fall-through beat consumed straight from data_i
    logic w_store;    // accepted beat goes into storage
    logic w_unload;   // consumed beat comes out of storage

    always_comb begin
        w_gate  = rst | flush_i;
        w_empty = (r_count == '0);

        // Occupancy only: a pop at full does not open the input this cycle.
        ready_o = !w_gate && (r_count < C_DEPTH);

        if (FALL_THROUGH && w_empty) begin
            valid_o = !w_gate && valid_i;
            data_o  = data_i;
        end else begin
            valid_o = !w_gate && !w_empty;
            data_o  = r_mem[r_rd_ptr];
        end

        w_push   = valid_i && ready_o;
        w_pop    = valid_o && ready_i;
        w_bypass = FALL_THROUGH && w_empty && w_push && w_pop;
        w_store  = w_push && !w_bypass;
        w_unload = w_pop && !w_bypass;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_unload) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_store, w_unload})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush leaves the payload storage untouched; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_fifo
// Purpose  : Directed bench for skid_fifo. Three instances:
//            inst 0 = DEPTH 2 fall-through, inst 1 = DEPTH 4 registered,
//            inst 2 = DEPTH 4 fall-through. Expected output beats are queued
//            per instance when stimulus is issued; a negedge monitor pops and
//            compares every consumed beat. Occupancy/handshake values are
//            checked directly from the stimulus process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skid_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst;
    logic [2:0]      flush;
    logic [2:0]      vin;
    logic [2:0]      rdy_in;
    logic [2:0][7:0] din;
    logic [2:0]      rdy_out;
    logic [2:0]      vout;
    logic [2:0][7:0] dout;
    logic [1:0]      cnt_a;
    logic [2:0]      cnt_b;
    logic [2:0]      cnt_c;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int n_cmp  = 0;
    int n_fail = 0;

    skid_fifo #(.T(logic [7:0]), .DEPTH(2), .FALL_THROUGH(1'b1)) u_a (
        .clk(clk), .rst(rst[0]), .flush_i(flush[0]), .valid_i(vin[0]),
        .data_i(din[0]), .ready_o(rdy_out[0]), .valid_o(vout[0]),
        .data_o(dout[0]), .ready_i(rdy_in[0]), .count_o(cnt_a)
    );

    skid_fifo #(.T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b0)) u_b (
        .clk(clk), .rst(rst[1]), .flush_i(flush[1]), .valid_i(vin[1]),
        .data_i(din[1]), .ready_o(rdy_out[1]), .valid_o(vout[1]),
        .data_o(dout[1]), .ready_i(rdy_in[1]), .count_o(cnt_b)
    );

    skid_fifo #(.T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b1)) u_c (
        .clk(clk), .rst(rst[2]), .flush_i(flush[2]), .valid_i(vin[2]),
        .data_i(din[2]), .ready_o(rdy_out[2]), .valid_o(vout[2]),
        .data_o(dout[2]), .ready_i(rdy_in[2]), .count_o(cnt_c)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every consumed beat must match the queue head.
    logic [7:0] mon_exp;
    int         mon_qsz;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vout[k] && rdy_in[k]) begin
                case (k)
                    0:       mon_qsz = q0.size();
                    1:       mon_qsz = q1.size();
                    default: mon_qsz = q2.size();
                endcase
                n_cmp++;
                if (mon_qsz == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat[%0d]: got 0x%02h, required no beat", k, dout[k]);
                end else begin
                    case (k)
                        0:       mon_exp = q0.pop_front();
                        1:       mon_exp = q1.pop_front();
                        default: mon_exp = q2.pop_front();
                    endcase
                    if (dout[k] !== mon_exp) begin
                        n_fail++;
                        $display("FAIL out[%0d]: got 0x%02h, required 0x%02h", k, dout[k], mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] pat;
    int          nxt;
    int          maxc;

    initial begin
        rst    = 3'b111;
        flush  = 3'b000;
        vin    = 3'b000;
        rdy_in = 3'b000;
        din    = '0;

        // ---------------- reset state ----------------
        cyc();
        smp();
        chk("rst_ready_o", int'(rdy_out[1]), 0);
        chk("rst_valid_o", int'(vout[1]), 0);
        cyc();
        rst = 3'b000;
        smp();
        chk("init_count_a", int'(cnt_a), 0);
        chk("init_count_b", int'(cnt_b), 0);
        chk("init_ready_a", int'(rdy_out[0]), 1);
        chk("init_ready_b", int'(rdy_out[1]), 1);
        chk("init_ready_c", int'(rdy_out[2]), 1);
        cyc();

        // ---------------- bypass, DEPTH 2 fall-through ----------------
        q0.push_back(8'hA1);
        vin[0] = 1'b1; din[0] = 8'hA1; rdy_in[0] = 1'b1;
        smp();
        chk("bypass_valid_o", int'(vout[0]), 1);
        chk("bypass_data_o", int'(dout[0]), 'hA1);
        chk("bypass_count", int'(cnt_a), 0);
        chk("bypass_ready_o", int'(rdy_out[0]), 1);
        cyc();
        vin[0] = 1'b0;
        smp();
        chk("bypass_count_after", int'(cnt_a), 0);
        chk("bypass_ready_after", int'(rdy_out[0]), 1);
        cyc();
        rdy_in[0] = 1'b0;

        // ---------------- full with simultaneous pop, DEPTH 2 ----------------
        q0.push_back(8'hB0);
        q0.push_back(8'hB1);
        vin[0] = 1'b1; din[0] = 8'hB0;
        smp();
        cyc();
        din[0] = 8'hB1;
        smp();
        chk("full_count1", int'(cnt_a), 1);
        cyc();
        vin[0] = 1'b0;
        smp();
        chk("full_count2", int'(cnt_a), 2);
        chk("full_ready_o", int'(rdy_out[0]), 0);
        chk("full_valid_o", int'(vout[0]), 1);
        chk("full_hold_data", int'(dout[0]), 'hB0);
        cyc();
        vin[0] = 1'b1; din[0] = 8'hB2; rdy_in[0] = 1'b1;
        smp();
        chk("fullpop_ready_o", int'(rdy_out[0]), 0);
        cyc();
        q0.push_back(8'hB2);
        smp();
        chk("fullpop_count", int'(cnt_a), 1);
        chk("fullpop_ready_next", int'(rdy_out[0]), 1);
        cyc();
        vin[0] = 1'b0;
        smp();
        chk("pushpop_count", int'(cnt_a), 1);
        cyc();
        rdy_in[0] = 1'b0;
        smp();
        chk("drain_count_a", int'(cnt_a), 0);
        cyc();

        // ---------------- fill and backpressure, DEPTH 4 registered ----------------
        for (int i = 0; i < 4; i++) begin
            vin[1] = 1'b1;
            din[1] = 8'h10 + 8'(i);
            q1.push_back(8'h10 + 8'(i));
            smp();
            chk("fill_count", int'(cnt_b), i);
            cyc();
        end
        din[1] = 8'h14;
        q1.push_back(8'h14);
        smp();
        chk("fill_count4", int'(cnt_b), 4);
        chk("fill_ready_o", int'(rdy_out[1]), 0);
        chk("fill_valid_o", int'(vout[1]), 1);
        chk("fill_head", int'(dout[1]), 'h10);
        cyc();
        smp();
        chk("fill_not_accepted", int'(cnt_b), 4);
        cyc();
        rdy_in[1] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            smp();
            chk("drain_valid_o", int'(vout[1]), 1);
            if (j == 0) chk("drain_ready_full", int'(rdy_out[1]), 0);
            if (j == 1) chk("drain_ready_open", int'(rdy_out[1]), 1);
            cyc();
            if (j == 1) vin[1] = 1'b0;
        end
        smp();
        chk("drain_count_b", int'(cnt_b), 0);
        chk("drain_valid_end", int'(vout[1]), 0);
        cyc();
        rdy_in[1] = 1'b0;

        // ---------------- wrap-around, DEPTH 4 fall-through ----------------
        pat  = 32'h9A6C_35B3;
        nxt  = 0;
        maxc = 0;
        for (int v = 0; v < 20; v++) q2.push_back(8'(v));
        for (int c = 0; c < 300 && !(nxt == 20 && q2.size() == 0); c++) begin
            rdy_in[2] = pat[c % 32];
            vin[2]    = (nxt < 20);
            din[2]    = nxt[7:0];
            smp();
            if (int'(cnt_c) > maxc) maxc = int'(cnt_c);
            if (vin[2] && rdy_out[2]) nxt++;
            cyc();
        end
        vin[2] = 1'b0;
        rdy_in[2] = 1'b0;
        chk("wrap_accepted", nxt, 20);
        chk("wrap_drained", q2.size(), 0);
        chk("wrap_max_le_depth", int'(maxc <= 4), 1);
        cyc();

        // ---------------- flush mid-stream, DEPTH 4 registered ----------------
        for (int i = 0; i < 3; i++) begin
            vin[1] = 1'b1;
            din[1] = 8'h21 + 8'(i);
            cyc();
        end
        vin[1] = 1'b0;
        smp();
        chk("preflush_count", int'(cnt_b), 3);
        cyc();
        flush[1] = 1'b1; vin[1] = 1'b1; din[1] = 8'h2F; rdy_in[1] = 1'b1;
        smp();
        chk("flush_valid_o", int'(vout[1]), 0);
        chk("flush_ready_o", int'(rdy_out[1]), 0);
        cyc();
        flush[1] = 1'b0; din[1] = 8'h30;
        q1.push_back(8'h30);
        smp();
        chk("postflush_count", int'(cnt_b), 0);
        chk("postflush_ready", int'(rdy_out[1]), 1);
        chk("postflush_valid", int'(vout[1]), 0);
        cyc();
        vin[1] = 1'b0;
        smp();
        chk("postflush_out_valid", int'(vout[1]), 1);
        cyc();
        smp();
        chk("postflush_drained", int'(cnt_b), 0);
        cyc();
        rdy_in[1] = 1'b0;

        // ---------------- reset mid-operation, DEPTH 4 fall-through ----------------
        for (int i = 0; i < 3; i++) begin
            vin[2] = 1'b1;
            din[2] = 8'h41 + 8'(i);
            cyc();
        end
        vin[2] = 1'b0;
        smp();
        chk("prerst_count", int'(cnt_c), 3);
        cyc();
        rst[2] = 1'b1; vin[2] = 1'b1; din[2] = 8'h4F; rdy_in[2] = 1'b1;
        smp();
        chk("midrst_valid_o", int'(vout[2]), 0);
        chk("midrst_ready_o", int'(rdy_out[2]), 0);
        cyc();
        rst[2] = 1'b0; vin[2] = 1'b0;
        smp();
        chk("postrst_count", int'(cnt_c), 0);
        chk("postrst_ready", int'(rdy_out[2]), 1);
        chk("postrst_valid", int'(vout[2]), 0);
        repeat (3) cyc();
        q2.push_back(8'h50);
        vin[2] = 1'b1; din[2] = 8'h50;
        smp();
        chk("postrst_bypass_valid", int'(vout[2]), 1);
        cyc();
        vin[2] = 1'b0;
        smp();
        chk("postrst_bypass_count", int'(cnt_c), 0);
        cyc();
        rdy_in[2] = 1'b0;
        repeat (2) cyc();

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
